// File: rtl/tgt_ddr_pkg.sv
`default_nettype none
// tgt_ddr_pkg: serializer mode codes and read-sequencer state encoding shared by the target DDR blocks.
package tgt_ddr_pkg;

  localparam logic [2:0] PREAMBLE_ZERO    = 3'b000;
  localparam logic [2:0] PREAMBLE_ONE     = 3'b001;
  localparam logic [2:0] SERIALIZING_BYTE = 3'b011;
  localparam logic [2:0] CRC_TOKEN        = 3'b010;
  localparam logic [2:0] PAR_VALUE        = 3'b110;
  localparam logic [2:0] CRC_VALUE        = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ACK     = 4'd1,
    ST_NACK    = 4'd2,
    ST_BYTE_HI = 4'd3,
    ST_BYTE_LO = 4'd4,
    ST_PARITY  = 4'd5,
    ST_FOLLOW  = 4'd6,
    ST_CRC_TOK = 4'd7,
    ST_CRC_VAL = 4'd8,
    ST_DONE    = 4'd9
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/tgt_rd_addr_gen.sv
`default_nettype none
// tgt_rd_addr_gen: word index, last-word compare and register-file address adder for the read sequencer.
module tgt_rd_addr_gen
  import tgt_ddr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic              lo_sel,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic [ADDR_W-1:0] base_in,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] base_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      base_q <= '0;
    end else if (load) begin
      idx_q  <= '0;
      cnt_q  <= cnt_in;
      base_q <= base_in;
    end else if (inc) begin
      idx_q  <= idx_q + CNT_W'(1);
    end
  end

  // Two bytes per word; the sum wraps silently at 2^ADDR_W.
  assign addr = base_q + ADDR_W'({idx_q, 1'b0}) + ADDR_W'(lo_sel);
  assign last = (idx_q == cnt_q - CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/tgt_ddr_rd_seq.sv
`default_nettype none
// tgt_ddr_rd_seq: HDR-DDR target read-response sequencer (preamble, data words, CRC).
// Optional abort path enabled by defining TGT_RD_ABORT_EN.
module tgt_ddr_rd_seq
  import tgt_ddr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              i_sys_clk,
  input  logic              i_sys_rst,
  input  logic              i_start,
  input  logic              i_nack,
  input  logic [CNT_W-1:0]  i_word_cnt,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_tx_mode_done,
  input  logic              i_abort,
  output logic              o_tx_en,
  output logic [2:0]        o_tx_mode,
  output logic [ADDR_W-1:0] o_regf_addr,
  output logic              o_regf_rd_en,
  output logic              o_crc_init,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_nacked,
  output logic              o_aborted
);

  rd_state_t state, state_nxt;
  logic      load, inc, lo_sel, last;
  logic      crc_init_q, nack_q, nack_nxt;
  logic      abort_hit;

  tgt_rd_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk     (i_sys_clk),
    .rst_n   (i_sys_rst),
    .load    (load),
    .inc     (inc),
    .lo_sel  (lo_sel),
    .cnt_in  (i_word_cnt),
    .base_in (i_base_addr),
    .addr    (o_regf_addr),
    .last    (last)
  );

`ifdef TGT_RD_ABORT_EN
  logic aborted_q;

  assign abort_hit = i_abort && (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) aborted_q <= 1'b0;
    else            aborted_q <= abort_hit;
  end

  assign o_aborted = aborted_q;
`else
  logic unused_abort;

  assign unused_abort = i_abort;
  assign abort_hit    = 1'b0;
  assign o_aborted    = 1'b0;
`endif

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state      <= ST_IDLE;
      crc_init_q <= 1'b0;
      nack_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      crc_init_q <= load;
      nack_q     <= nack_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    nack_nxt     = nack_q;
    load         = 1'b0;
    inc          = 1'b0;
    lo_sel       = 1'b0;
    o_tx_en      = 1'b0;
    o_tx_mode    = PREAMBLE_ZERO;
    o_regf_rd_en = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_start) begin
          load      = 1'b1;
          nack_nxt  = i_nack || (i_word_cnt == '0);
          state_nxt = nack_nxt ? ST_NACK : ST_ACK;
        end
      end
      ST_ACK: begin
        o_tx_en = 1'b1;
        if (i_tx_mode_done) state_nxt = ST_BYTE_HI;
      end
      ST_NACK: begin
        o_tx_en   = 1'b1;
        o_tx_mode = PREAMBLE_ONE;
        if (i_tx_mode_done) state_nxt = ST_DONE;
      end
      ST_BYTE_HI: begin
        o_tx_en      = 1'b1;
        o_tx_mode    = SERIALIZING_BYTE;
        o_regf_rd_en = 1'b1;
        if (i_tx_mode_done) state_nxt = ST_BYTE_LO;
      end
      ST_BYTE_LO: begin
        o_tx_en      = 1'b1;
        o_tx_mode    = SERIALIZING_BYTE;
        o_regf_rd_en = 1'b1;
        lo_sel       = 1'b1;
        if (i_tx_mode_done) state_nxt = ST_PARITY;
      end
      ST_PARITY: begin
        o_tx_en   = 1'b1;
        o_tx_mode = PAR_VALUE;
        if (i_tx_mode_done) state_nxt = last ? ST_CRC_TOK : ST_FOLLOW;
      end
      ST_FOLLOW: begin
        o_tx_en   = 1'b1;
        o_tx_mode = PREAMBLE_ONE;
        if (i_tx_mode_done) begin
          inc       = 1'b1;
          state_nxt = ST_BYTE_HI;
        end
      end
      ST_CRC_TOK: begin
        o_tx_en   = 1'b1;
        o_tx_mode = CRC_TOKEN;
        if (i_tx_mode_done) state_nxt = ST_CRC_VAL;
      end
      ST_CRC_VAL: begin
        o_tx_en   = 1'b1;
        o_tx_mode = CRC_VALUE;
        if (i_tx_mode_done) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    // Abort overrides any phase advance in the same cycle.
    if (abort_hit) begin
      state_nxt = ST_IDLE;
      inc       = 1'b0;
    end
  end

  assign o_crc_init = crc_init_q;
  assign o_busy     = (state != ST_IDLE);
  assign o_done     = (state == ST_DONE);
  assign o_nacked   = (state == ST_DONE) && nack_q;

endmodule
`default_nettype wire
